swap_ctrl: RTL
==============

// Module: swap_ctrl
// PURPOSE
//  Sequencer for the memory swapper datapath. On start it latches two addresses,
//  reads both words, then writes each word into the other location.
//  It drives the 2-bit address-mux select (0=ext write addr, 1=addr 0, 2=A, 3=B),
//  the RAM enables and the write data. It gates the external write port while a swap runs.
// PARAMETERS
//  addr_w_N     7  address width (RAM depth 2**addr_w_N)
//  data_w_Bits  8  data word width
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            async active-high reset
//  start        in   1            request swap; sampled only in IDLE
//  addr_A_in    in   addr_w_N     first location, latched on accepted start
//  addr_B_in    in   addr_w_N     second location, latched on accepted start
//  ext_we       in   1            external write request (sel=0 path)
//  ext_wdata    in   data_w_Bits  external write data
//  rd_data      in   data_w_Bits  RAM read data, valid 1 cycle after mem_re
//  sel          out  2            address-mux select
//  address_A    out  addr_w_N     latched A, to mux input 2
//  address_B    out  addr_w_N     latched B, to mux input 3
//  mem_re       out  1            RAM read enable
//  mem_we       out  1            RAM write enable
//  wr_data      out  data_w_Bits  RAM write data
//  busy         out  1            high in every state except IDLE
//  done         out  1            1-cycle pulse at swap completion
//  swap_count   out  16           completed swaps, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async): state=IDLE; sel=0, mem_re=0, mem_we=0, wr_data=0, busy=0, done=0,
//   address_A=address_B=0, tmpA=tmpB=0, swap_count=0. Mid-swap reset aborts at once.
//   RAM may hold one partially written word. No recovery is attempted.
//  All outputs are registered or decoded from state only; no comb path from inputs,
//   except mem_we/wr_data in IDLE.
//  IDLE: sel=0, mem_we=ext_we, wr_data=ext_wdata, mem_re=0.
//   start=1 -> latch addr_A_in/addr_B_in, go RD_A.
//   If addr_A_in==addr_B_in -> go DONE directly (no RAM access).
//  RD_A   : sel=2, mem_re=1                                   -> RD_B
//  RD_B   : sel=3, mem_re=1; tmpA<=rd_data at cycle end       -> CAP_B
//  CAP_B  : sel=3, no enables; tmpB<=rd_data at cycle end     -> WR_A
//  WR_A   : sel=2, mem_we=1, wr_data=tmpB                     -> WR_B
//  WR_B   : sel=3, mem_we=1, wr_data=tmpA                     -> DONE
//  DONE   : done=1, sel=0, no enables; swap_count+=1          -> IDLE
//  Latency: start accepted at edge N; done high in cycle N+6 (N+1 if A==B).
//  Next start is accepted in the cycle after DONE.
//  While busy: start ignored (not queued); ext_we ignored, mem_we only from FSM.
//  sel=1 is never driven by this block (reserved for the clear path).
//  Address/data changes on *_in while busy have no effect.
// TESTING
//  1 RAM[5]=0x11,RAM[9]=0x22; start A=5,B=9 -> done at +6 cyc; RAM[5]=0x22,RAM[9]=0x11
//  2 start A=B=3 with RAM[3]=0x7E -> done at +1 cyc; no mem_re/mem_we; RAM[3]=0x7E
//  3 start again at cycle 3 of a swap, plus ext_we to addr 5 -> both ignored; one done; count+1
//  4 rst asserted during WR_A -> all outputs 0 same cycle; IDLE; next swap completes correctly
//  5 A=0,B=127 (addr_w_N=7) extreme addresses -> swapped; sel sequence 2,3,3,2,3,0 verified
//  6 65536 back-to-back swaps -> swap_count wraps to 0; done pulses exactly once each

Source files
------------

// File: rtl/swap_ctrl.sv
// Sequencer for the memory swapper: latches two addresses, reads both words, then
// writes each word into the other location while gating the external write port.
module swap_ctrl #(
    parameter int addr_w_N    = 7,
    parameter int data_w_Bits = 8,
    parameter int cnt_w_N     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [addr_w_N-1:0]    i_addr_A_in,
    input  logic [addr_w_N-1:0]    i_addr_B_in,
    input  logic                   i_ext_we,
    input  logic [data_w_Bits-1:0] i_ext_wdata,
    input  logic [data_w_Bits-1:0] i_rd_data,
    output logic [1:0]             o_sel,
    output logic [addr_w_N-1:0]    o_address_A,
    output logic [addr_w_N-1:0]    o_address_B,
    output logic                   o_mem_re,
    output logic                   o_mem_we,
    output logic [data_w_Bits-1:0] o_wr_data,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [cnt_w_N-1:0]     o_swap_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_CAP_B,
        S_WR_A,
        S_WR_B,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [addr_w_N-1:0]    r_addr_a;
    logic [addr_w_N-1:0]    r_addr_b;
    logic [data_w_Bits-1:0] r_tmp_a;
    logic [data_w_Bits-1:0] r_tmp_b;
    logic [cnt_w_N-1:0]     r_count;
    logic                   w_accept;

    assign w_accept     = (r_state == S_IDLE) && i_start;
    assign o_address_A  = r_addr_a;
    assign o_address_B  = r_addr_b;
    assign o_swap_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Read data arrives one cycle after its read enable, so each word is captured
    // in the state following its read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_tmp_a  <= '0;
            r_tmp_b  <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_addr_a <= i_addr_A_in;
                r_addr_b <= i_addr_B_in;
            end
            if (r_state == S_RD_B) begin
                r_tmp_a <= i_rd_data;
            end
            if (r_state == S_CAP_B) begin
                r_tmp_b <= i_rd_data;
            end
            if (r_state == S_DONE) begin
                r_count <= r_count + cnt_w_N'(1);
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        o_sel     = 2'd0;
        o_mem_re  = 1'b0;
        o_mem_we  = 1'b0;
        o_wr_data = '0;
        o_busy    = 1'b1;
        o_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Only idle state passes the external write port through.
                o_busy    = 1'b0;
                o_mem_we  = i_ext_we;
                o_wr_data = i_ext_wdata;
                if (i_start) begin
                    w_next = (i_addr_A_in == i_addr_B_in) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A: begin
                o_sel    = 2'd2;
                o_mem_re = 1'b1;
                w_next   = S_RD_B;
            end
            S_RD_B: begin
                o_sel    = 2'd3;
                o_mem_re = 1'b1;
                w_next   = S_CAP_B;
            end
            S_CAP_B: begin
                o_sel  = 2'd3;
                w_next = S_WR_A;
            end
            S_WR_A: begin
                o_sel     = 2'd2;
                o_mem_we  = 1'b1;
                o_wr_data = r_tmp_b;
                w_next    = S_WR_B;
            end
            S_WR_B: begin
                o_sel     = 2'd3;
                o_mem_we  = 1'b1;
                o_wr_data = r_tmp_a;
                w_next    = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
